// File: rtl/uart_echo_core.sv
// 8N1 UART loopback: every byte received on rxd is retransmitted unchanged on txd.
// Define UART_ECHO_FRAME_CHECK_EN to drop bytes whose stop bit samples low.
module uart_echo_core #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic clock,
  input  logic reset,
  output logic txd,
  input  logic rxd,
  output logic datasent,
  output logic transmit
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rxd_meta_q, rxd_meta_d;
  logic             rxd_sync_q, rxd_sync_d;
  logic             rxd_prev_q, rxd_prev_d;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_done_s;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             hold_valid_q, hold_valid_d;
  logic [1:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_load_s;
  logic             txd_q, txd_d;
  logic             transmit_q, transmit_d;
  logic             datasent_q, datasent_d;

  // Receiver: synchronizer, falling-edge arm, mid-bit sampling.
  always_comb begin
    rxd_meta_d = rxd;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_s  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxd_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
`ifdef UART_ECHO_FRAME_CHECK_EN
        // A low stop sample parks the counter at CNT_WAIT until the line recovers.
        if (rx_cnt_q == CNT_WAIT) begin
          if (rxd_sync_q) begin
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = CNT_WAIT;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_done_s = rxd_sync_q;
          if (rxd_sync_q) begin
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = CNT_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
`else
        if (rx_cnt_q == BIT_LAST) begin
          rx_done_s  = 1'b1;
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
`endif
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // One-entry holding register; a byte arriving while it is full is dropped.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (tx_load_s) begin
      hold_valid_d = 1'b0;
    end else if (rx_done_s && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = rx_shift_q;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Transmitter frame sequencing.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_load_s  = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (hold_valid_q) begin
          tx_load_s  = 1'b1;
          tx_shift_d = hold_data_q;
          tx_state_d = S_START;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = '0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next TX state so they register in step with it.
  always_comb begin
    case (tx_state_d)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_shift_d[0];
      S_STOP:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
    transmit_d = (tx_state_d != S_IDLE);
    datasent_d = (tx_state_d == S_STOP) && (tx_cnt_d == BIT_LAST);
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'h00;
      txd_q        <= 1'b1;
      transmit_q   <= 1'b0;
      datasent_q   <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      rxd_prev_q   <= rxd_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      transmit_q   <= transmit_d;
      datasent_q   <= datasent_d;
    end
  end

  assign txd      = txd_q;
  assign transmit = transmit_q;
  assign datasent = datasent_q;

endmodule

// File: tb/tb_uart_echo_core.sv
// Bench for uart_echo_core: directed serial stimulus plus a frame-level echo model.
module tb_uart_echo_core;

  localparam int CPB       = 868;
  localparam int FRAME_CYC = 10 * CPB;
`ifdef UART_ECHO_FRAME_CHECK_EN
  localparam int ECHO_3C = 0;
`else
  localparam int ECHO_3C = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rxd   = 1'b1;
  logic txd;
  logic datasent;
  logic transmit;

  always #5 clock = ~clock;

  uart_echo_core dut (
    .clock    (clock),
    .reset    (reset),
    .txd      (txd),
    .rxd      (rxd),
    .datasent (datasent),
    .transmit (transmit)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         in_frame   = 1'b0;
  bit         cur_valid  = 1'b0;
  bit         just_ended = 1'b0;
  int         k = 0;
  logic [9:0] cur_frame = 10'h3FF;
  int         ds_count = 0;
  int         ds_before;

  // Line image of one 8N1 frame, index = bit time: start 0, data LSB first, stop 1.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle the line must be idle, inside an expected frame, or in reset.
  always @(negedge clock) begin
    if (!reset) begin
      check(txd === 1'b1 && transmit === 1'b0 && datasent === 1'b0, "reset_outputs",
            {29'd0, txd, transmit, datasent}, 32'h4);
      in_frame   = 1'b0;
      just_ended = 1'b0;
    end else begin
      if (datasent) ds_count++;
      if (just_ended) begin
        check(transmit === 1'b0 && txd === 1'b1 && datasent === 1'b0, "after_frame",
              {29'd0, txd, transmit, datasent}, 32'h4);
        just_ended = 1'b0;
      end else if (!in_frame) begin
        if (transmit === 1'b1) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_echo", 32'd1, 32'd0);
            cur_valid = 1'b0;
          end else begin
            cur_frame = frame_of(exp_q.pop_front());
            cur_valid = 1'b1;
          end
          in_frame = 1'b1;
          k        = 0;
        end else begin
          check(txd === 1'b1 && datasent === 1'b0, "idle_line", {30'd0, txd, datasent}, 32'h2);
        end
      end
      if (in_frame) begin
        if (cur_valid) begin
          check(transmit === 1'b1, "transmit_high", {31'd0, transmit}, 32'd1);
          check(txd === cur_frame[k / CPB], "txd_bit", {31'd0, txd}, {31'd0, cur_frame[k / CPB]});
          check(datasent === (k == FRAME_CYC - 1), "datasent_pos", {31'd0, datasent},
                {31'd0, (k == FRAME_CYC - 1)});
        end
        k++;
        if (k == FRAME_CYC) begin
          in_frame   = 1'b0;
          just_ended = 1'b1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clock);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || just_ended) && n < 40000) begin
      @(negedge clock);
      n++;
    end
    check(n < 40000, "echo_timeout", n, 32'd40000);
    idle(5);
  endtask

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    idle(4);
    #2 reset = 1'b1;

    check(frame_of(8'h55) == 10'h2AA, "model_frame_55", {22'd0, frame_of(8'h55)}, 32'h2AA);
    check(frame_of(8'hA3) == 10'h346, "model_frame_A3", {22'd0, frame_of(8'hA3)}, 32'h346);

    idle(20000);
    check(ds_count == 0, "idle_no_datasent", ds_count, 32'd0);

    // 0x55, then a short glitch while its echo is still on the wire.
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(1000);
    rxd = 1'b0;
    idle(300);
    rxd = 1'b1;
    idle(1000);

    // Back to back: A3, 00, then 3C with a low stop bit.
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    if (ECHO_3C != 0) exp_q.push_back(8'h3C);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(1000);

    // 0xFF interrupted by reset in mid frame.
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    begin
      int n = 0;
      while (!(in_frame && cur_valid && exp_q.size() == 0 && k >= 5 * CPB) && n < 30000) begin
        @(negedge clock);
        n++;
      end
      check(n < 30000, "ff_echo_timeout", n, 32'd30000);
    end
    check(ds_count == 3 + ECHO_3C, "datasent_count_pre_reset", ds_count, 3 + ECHO_3C);
    ds_before = ds_count;
    #2 reset = 1'b0;
    #1;
    check(txd === 1'b1, "reset_txd_now", {31'd0, txd}, 32'd1);
    check(transmit === 1'b0, "reset_transmit_now", {31'd0, transmit}, 32'd0);
    idle(4);
    #2 reset = 1'b1;
    idle(2000);
    check(ds_count == ds_before, "no_datasent_after_abort", ds_count, ds_before);

    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_done();
    check(ds_count == 4 + ECHO_3C, "datasent_count_final", ds_count, 4 + ECHO_3C);
    check(exp_q.size() == 0, "all_echoes_seen", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
